// File: rtl/ram_3d_stream_reader_if.sv
// Port-B read bus and output row stream of the
// 3D feature-map stream reader.
interface ram_3d_stream_reader_if #(
  parameter int ram_num = 16,
  parameter int width   = 16,
  parameter int address = 10
);
  logic               enb;
  logic               web;
  logic [address-1:0] addrb [0:ram_num-1];
  logic [width-1:0]   doutb [0:ram_num-1];
  logic               out_valid;
  logic               out_ready;
  logic [width-1:0]   out_data [0:ram_num-1];
  logic               out_last;

  modport master (
    output enb, web, addrb,
    input  doutb,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  enb, web, addrb,
    output doutb,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/ram_3d_stream_reader.sv
// Strided row reader for banked RAM port B with a
// 4-deep credit-managed row FIFO on a valid/ready stream.
module ram_3d_stream_reader #(
  parameter int ram_num = 16,
  parameter int width   = 16,
  parameter int address = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [address-1:0] base_addr,
  input  logic [address-1:0] stride,
  input  logic [address:0]   length,
  output logic               busy,
  output logic               done,
  ram_3d_stream_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [address:0] L0 = '0;
  localparam logic [address:0] L1 = (address+1)'(1);

  state_e             state_q, state_d;
  logic [address-1:0] next_q, next_d;
  logic [address-1:0] addrb_q, addrb_d;
  logic [address:0]   left_q, left_d;
  logic [address:0]   beats_q, beats_d;
  logic               enb_q, enb_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic [1:0]         wr_q, wr_d;
  logic [1:0]         rd_q, rd_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [width-1:0]   mem_q [0:3][0:ram_num-1];
  logic [width-1:0]   mem_d [0:3][0:ram_num-1];

  logic       push;
  logic       pop;
  logic       credit;
  logic [3:0] used;

  always_comb begin
    push   = vld_q;
    pop    = (cnt_q != 3'd0) && bus.out_ready;
    // credits count the FIFO plus reads still in flight
    used   = {1'b0, cnt_q} + {3'b0, enb_q}
           + {3'b0, vld_q};
    credit = used < 4'd4;

    state_d = state_q;
    next_d  = next_q;
    addrb_d = addrb_q;
    left_d  = left_q;
    beats_d = beats_q;
    enb_d   = 1'b0;
    vld_d   = enb_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;

    if (pop) begin
      beats_d = beats_q - L1;
      rd_d    = rd_q + 2'd1;
    end
    if (push) begin
      for (int i = 0; i < ram_num; i++)
        mem_d[wr_q][i] = bus.doutb[i];
      wr_d = wr_q + 2'd1;
    end
    cnt_d = cnt_q + {2'b0, push}
          - {2'b0, pop};

    unique case (state_q)
      IDLE: begin
        if (start && length == L0) begin
          done_d = 1'b1;
        end else if (start) begin
          enb_d   = 1'b1;
          addrb_d = base_addr;
          next_d  = base_addr + stride;
          left_d  = length - L1;
          beats_d = length;
          state_d = (length == L1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (credit) begin
          enb_d   = 1'b1;
          addrb_d = next_q;
          next_d  = next_q + stride;
          left_d  = left_q - L1;
          if (left_q == L1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && beats_q == L1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      next_q  <= '0;
      addrb_q <= '0;
      left_q  <= '0;
      beats_q <= '0;
      enb_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int e = 0; e < 4; e++)
        for (int i = 0; i < ram_num; i++)
          mem_q[e][i] <= '0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      addrb_q <= addrb_d;
      left_q  <= left_d;
      beats_q <= beats_d;
      enb_q   <= enb_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    busy          = state_q != IDLE;
    done          = done_q;
    bus.enb       = enb_q;
    bus.web       = 1'b0;
    bus.out_valid = cnt_q != 3'd0;
    bus.out_last  = bus.out_valid
                 && beats_q == L1;
    for (int i = 0; i < ram_num; i++) begin
      bus.addrb[i]    = addrb_q;
      bus.out_data[i] = bus.out_valid
                      ? mem_q[rd_q][i] : '0;
    end
  end

endmodule

// File: doc/ram_3d_stream_reader.md
# ram_3d_stream_reader

Streaming read controller for port B of the banked dual-port RAM. On a start command it walks a strided row sequence, reads the same row address from every bank in parallel, and absorbs the RAM's fixed one-cycle read latency. It returns each bank-wide row as one beat on a valid/ready stream, honouring downstream backpressure without dropping or duplicating rows. It sits between the banked feature-map RAM and the next compute stage.

## Interface
- `ram_num`, 16, number of banks (matches the RAM instance)
- `width`, 16, bits per bank word
- `address`, 10, row address bits per bank; the row space is 2**address

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: command pulse; accepted only while `busy`=0
- `base_addr` in `address`: first row, sampled with an accepted `start`
- `stride` in `address`: row increment, sampled with an accepted `start`
- `length` in `address+1`: number of rows, 0..2**address, sampled with an accepted `start`
- `busy` out 1: command in progress
- `done` out 1: one-cycle pulse at command completion
- `enb` out 1: RAM port B enable, registered
- `web` out 1: RAM port B write enable, constant 0
- `addrb` out `address` x [0:ram_num-1]: port B address; all entries equal, registered
- `doutb` in `width` x [0:ram_num-1]: RAM port B read data, valid the cycle after `enb`
- `out_valid` out 1: beat available
- `out_ready` in 1: downstream accepts the beat
- `out_data` out `width` x [0:ram_num-1]: beat payload; entry i comes from bank i
- `out_last` out 1: marks the final beat of a command

## Operation
- States:
  - IDLE: waiting for a command.
  - RUN: issuing reads.
  - DRAIN: all reads issued, waiting for the buffer to empty.
- Transitions:
  - IDLE→RUN when `start`=1 and `length`≠0.
  - IDLE with `start`=1 and `length`=0: `done` pulses next cycle; no reads are issued and `busy` stays 0.
  - RUN→DRAIN when the last read is issued.
  - DRAIN→IDLE on the handshake of the `out_last` beat.
- Row k uses address (`base_addr` + k·`stride`) mod 2**address. Wrap-around is silent.
- Output buffer: 4-entry FIFO of bank-wide rows, in order.
- `pend` = number of reads issued but not yet written into the FIFO, range 0..2.
- Issue rule for cycle c: issue only if rows remain and fifo_count + `pend` < 4. The rule uses registered counts only, with no pop lookahead. An issue sets `enb`=1 in cycle c+1 with that row's address.
- `enb`=0 in every cycle without an issue. `addrb` holds its last value when `enb`=0.
- `doutb` is written into the FIFO in the cycle after `enb`=1, unconditionally. The credit rule guarantees space.
- Handshake: a beat transfers when `out_valid`&`out_ready`.
  - `out_data` and `out_last` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a transfer.
- `out_last`=1 only on beat `length`-1.
- `start` while `busy`=1 is ignored. The command registers are not altered.
- `busy`=1 in RUN and DRAIN. `done` is registered and pulses in the cycle after the last handshake, with `busy`=0 in that cycle. A new `start` in the `done` cycle is accepted.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - `busy`, `done`, `enb`, `web`, `out_valid`, `out_last` = 0
  - every `addrb` and `out_data` entry = 0
  - state IDLE, FIFO empty, `pend`=0
- Reset mid-command abandons the command. Any in-flight `doutb` is discarded.
- `start` is sampled at the edge ending cycle 0. Then:
  - `enb`=1 in cycle 1
  - first `out_valid`=1 in cycle 3
- With `out_ready` held at 1, rows issue every cycle and beats emerge every cycle. `length`=N gives beats in cycles 3..N+2 and `done` in cycle N+3.
- With `out_ready` held at 0 from the start, exactly 4 reads issue, then `enb` stays 0 until a pop frees a credit. The next `enb` follows that pop by 1 cycle.
- FIFO push and pop in the same cycle are both allowed; the count is unchanged.

## Test plan
- Preload bank i row a with (i<<10)|a. Command `base_addr`=0x010, `stride`=1, `length`=4, `out_ready`=1 → `enb` high in cycles 1-4 with `addrb`=0x010..0x013; beats in cycles 3-6 with `out_data[i]`=(i<<10)|(0x010+k); `out_last` in cycle 6; `done` in cycle 7.
- `length`=8 with `out_ready`=0 for 20 cycles → exactly 4 `enb` cycles; `out_valid`=1 with row 0x010 held stable. Then raise `out_ready` → all 8 rows arrive in order with no gaps or duplicates.
- Command `base_addr`=0x3FE, `stride`=1, `length`=4 → `addrb` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Command `base_addr`=5, `stride`=3, `length`=3 with `out_ready` toggling 1,0,1,0 → addresses 5, 8, 11; payload stable while stalled; `done` exactly once.
- Stimulus, in order:
  - `length`=0 → `done` in cycle 1, no `enb`, no `out_valid`.
  - Then `start` pulsed while `busy`=1 → ignored.
- Pull `rst` low while beat 2 of 8 is valid → all outputs read 0 immediately. After release, a fresh `length`=2 command completes normally with `done` in cycle 5.
